c17_key_unlock_ctrl: RTL and testbench
======================================

Name: c17_key_unlock_ctrl

Overview:
- Key-management and unlock sequencer for the Anti-SAT-locked c17 core (inputs N1,N2,N3,N6,N7; key K1..K9; outputs N22,N23).
- Receives the 9-bit key serially from a secure key source and drives it onto the core's key pins.
- Runs a built-in known-answer self-test through the core, then releases the functional path only if every response matches.
- Repeated failures trigger a sticky lockout.

Parameters:
- NUM_VEC, 4, number of self-test vectors (1..8).
- TEST_VEC, 20'b01011_10100_11111_00000, packed vectors; vector i at [5i+4:5i], bit order {N1,N2,N3,N6,N7}, N1 MSB.
- GOLDEN, 8'b11_10_10_00, expected {N22,N23} for vector i at [2i+1:2i].
- DECOY_KEY, 9'h000, key driven while not loaded/verified.
- MAX_TRIES, 3, failed attempts allowed before lockout (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; begins a key load from IDLE or FAIL.
- key_bit  in  1  serial key bit.
- key_valid  in  1  key_bit valid.
- key_ready  out  1  controller accepts key_bit this cycle.
- func_in  in  5  system inputs {N1,N2,N3,N6,N7}.
- core_in  out  5  to locked core {N1,N2,N3,N6,N7}.
- core_out  in  2  from locked core {N22,N23}, combinational.
- key_out  out  9  to core; key_out[0]=K1 … key_out[8]=K9.
- func_out  out  2  system outputs {N22,N23}.
- busy  out  1  high in LOAD/APPLY/SAMPLE.
- unlocked  out  1  high in UNLOCKED.
- fail  out  1  high in FAIL.
- lockout  out  1  high in LOCKOUT.

Behaviour:
- Reset: state=IDLE, key_out=DECOY_KEY, shadow=0, bit_cnt=0, vec_idx=0, tries=0. All status outputs, key_ready, core_in and func_out are 0. An asynchronous reset in any state, mid-load included, returns everything to these values immediately.
- Every output is registered or decoded from the state register. core_out is the only combinational input sampled.
- IDLE: key_ready=0; start=1 -> LOAD with bit_cnt=0.
- LOAD: key_ready=1. Each cycle with key_valid&key_ready: shadow <= {key_bit, shadow[8:1]}, bit_cnt++, so the first bit ends up as K1.
  - On the 9th accept: key_out <= {key_bit, shadow[8:1]}, vec_idx=0 -> APPLY.
  - key_valid is ignored outside LOAD; start is ignored in LOAD.
- APPLY (1 cycle): core_in = TEST_VEC[vec_idx] -> SAMPLE.
- SAMPLE (1 cycle): core_in held.
  - core_out != GOLDEN[vec_idx] -> FAIL.
  - Match and vec_idx==NUM_VEC-1 -> UNLOCKED.
  - Otherwise vec_idx++ -> APPLY.
  - Self-test latency is 2*NUM_VEC cycles after the last key bit.
- FAIL entry: tries++ (saturating), key_out <= DECOY_KEY, shadow cleared.
  - If the new tries==MAX_TRIES -> LOCKOUT next cycle.
  - Otherwise stay in FAIL; start=1 -> LOAD.
- LOCKOUT: terminal until reset. key_out=DECOY_KEY, core_in=0, func_out=0; start and key_valid ignored.
- UNLOCKED: terminal until reset. core_in=func_in (combinational pass-through), func_out=core_out, key_out held, tries cleared to 0; start ignored.
- In every state except UNLOCKED: func_out=0. core_in=0, except during APPLY/SAMPLE.
- start and key_valid asserted together in IDLE: the bit is not accepted; accepts begin the cycle after LOAD entry.

Optional Feature:
- C17_KEY_PARITY_EN defined:
  - LOAD accepts 10 bits; the 10th is an odd-parity bit over the 9 key bits.
  - Parity error -> FAIL directly (counts as a try, no self-test run, key_out never updated).
  - Good parity -> APPLY as normal.
- Undefined: 9-bit load, no parity check.

Test Plan:
- Reset then idle: key_out=9'h000, all status 0, func_out=0; key_valid pulses while IDLE leave key_ready=0 and shadow unchanged.
- Correct key, bench core model returns golden iff key matches: 9 bits accepted (with random key_valid gaps) -> core_in sequence 00000, 11111, 10100, 01011 for 2 cycles each, core_out 00, 10, 10, 11 -> unlocked=1 exactly 8 cycles after the 9th accept; then func_in=5'b11111 -> func_out=2'b10.
- Wrong key, core returns 01 on vector 1 -> FAIL after SAMPLE of vector 1, key_out back to 9'h000, fail=1, tries=1.
- Three consecutive wrong-key attempts (start re-asserted from FAIL) -> lockout=1; a later start plus a correct key produces no key_ready and unlocked stays 0.
- Reset asserted after 5 key bits -> outputs cleared at once; a fresh load after reset with the correct key unlocks normally.
- With C17_KEY_PARITY_EN: 9 key bits plus a wrong parity bit -> FAIL with no APPLY cycle, key_out stays 9'h000; the correct parity bit -> self-test runs.

Source files
------------

// File: rtl/c17_key_unlock_ctrl.sv
// Key load, known-answer self-test and unlock sequencer for the Anti-SAT-locked c17 core.
// Define C17_KEY_PARITY_EN to load a 10th odd-parity bit and reject bad-parity keys before self-test.
//
// state    | meaning
// IDLE     | waiting for start, decoy key on the core
// LOAD     | shifting serial key bits into the shadow register
// APPLY    | driving self-test vector vec_idx onto the core
// SAMPLE   | comparing core response for vec_idx with its golden value
// FAIL     | attempt rejected, decoy key restored, may retry
// LOCKOUT  | too many failed attempts, terminal until reset
// UNLOCKED | self-test passed, functional path open, terminal until reset
module c17_key_unlock_ctrl #(
   parameter int                     NUM_VEC   = 4,
   parameter logic [5*NUM_VEC-1:0]   TEST_VEC  = 20'b01011_10100_11111_00000,
   parameter logic [2*NUM_VEC-1:0]   GOLDEN    = 8'b11_10_10_00,
   parameter logic [8:0]             DECOY_KEY = 9'h000,
   parameter int                     MAX_TRIES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       key_bit,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [4:0] func_in,
   output logic [4:0] core_in,
   input  logic [1:0] core_out,
   output logic [8:0] key_out,
   output logic [1:0] func_out,
   output logic       busy,
   output logic       unlocked,
   output logic       fail,
   output logic       lockout
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_APPLY, S_SAMPLE, S_FAIL, S_LOCKOUT, S_UNLOCKED
   } state_t;

   localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);
   localparam logic [3:0] MAX_T    = 4'(MAX_TRIES);
`ifdef C17_KEY_PARITY_EN
   localparam logic [3:0] LAST_BIT = 4'd9;
`else
   localparam logic [3:0] LAST_BIT = 4'd8;
`endif

   state_t     state_q, state_d;
   logic [8:0] shadow_q, shadow_d;
   logic [8:0] key_q, key_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [2:0] vec_idx_q, vec_idx_d;
   logic [3:0] tries_q, tries_d;
   logic [4:0] cur_vec;
   logic [1:0] cur_gold;
   logic       go_fail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         shadow_q  <= '0;
         key_q     <= DECOY_KEY;
         bit_cnt_q <= '0;
         vec_idx_q <= '0;
         tries_q   <= '0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         key_q     <= key_d;
         bit_cnt_q <= bit_cnt_d;
         vec_idx_q <= vec_idx_d;
         tries_q   <= tries_d;
      end
   end

   always_comb begin
      cur_vec  = '0;
      cur_gold = '0;
      for (int i = 0; i < NUM_VEC; i++) begin
         if (vec_idx_q == 3'(i)) begin
            cur_vec  = TEST_VEC[5*i +: 5];
            cur_gold = GOLDEN[2*i +: 2];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      key_d     = key_q;
      bit_cnt_d = bit_cnt_q;
      vec_idx_d = vec_idx_q;
      tries_d   = tries_q;
      go_fail   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_LOAD;
               bit_cnt_d = '0;
            end
         end
         S_LOAD: begin
            if (key_valid) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef C17_KEY_PARITY_EN
               if (bit_cnt_q == LAST_BIT) begin
                  // Odd parity: key bits plus parity bit must hold an odd number of ones.
                  if (^{shadow_q, key_bit}) begin
                     key_d     = shadow_q;
                     vec_idx_d = '0;
                     state_d   = S_APPLY;
                  end else begin
                     go_fail = 1'b1;
                  end
               end else begin
                  shadow_d = {key_bit, shadow_q[8:1]};
               end
`else
               shadow_d = {key_bit, shadow_q[8:1]};
               if (bit_cnt_q == LAST_BIT) begin
                  key_d     = {key_bit, shadow_q[8:1]};
                  vec_idx_d = '0;
                  state_d   = S_APPLY;
               end
`endif
            end
         end
         S_APPLY: state_d = S_SAMPLE;
         S_SAMPLE: begin
            if (core_out != cur_gold) begin
               go_fail = 1'b1;
            end else if (vec_idx_q == LAST_VEC) begin
               state_d = S_UNLOCKED;
               tries_d = '0;
            end else begin
               vec_idx_d = vec_idx_q + 3'd1;
               state_d   = S_APPLY;
            end
         end
         S_FAIL: begin
            if (tries_q == MAX_T) begin
               state_d = S_LOCKOUT;
            end else if (start) begin
               state_d   = S_LOAD;
               bit_cnt_d = '0;
            end
         end
         S_LOCKOUT, S_UNLOCKED: ;
         default: state_d = S_IDLE;
      endcase
      if (go_fail) begin
         state_d  = S_FAIL;
         tries_d  = (tries_q == 4'hF) ? tries_q : tries_q + 4'd1;
         key_d    = DECOY_KEY;
         shadow_d = '0;
      end
   end

   assign key_out   = key_q;
   assign key_ready = (state_q == S_LOAD);
   assign busy      = (state_q == S_LOAD) || (state_q == S_APPLY) || (state_q == S_SAMPLE);
   assign unlocked  = (state_q == S_UNLOCKED);
   assign fail      = (state_q == S_FAIL);
   assign lockout   = (state_q == S_LOCKOUT);
   assign core_in   = ((state_q == S_APPLY) || (state_q == S_SAMPLE)) ? cur_vec :
                      (state_q == S_UNLOCKED) ? func_in : 5'b00000;
   assign func_out  = (state_q == S_UNLOCKED) ? core_out : 2'b00;

endmodule

// File: tb/tb_c17_key_unlock_ctrl.sv
// Directed bench for c17_key_unlock_ctrl: vector table for the unlock flow plus reset, retry and lockout sequences.
module tb_c17_key_unlock_ctrl;

   localparam logic [8:0] GOOD_KEY = 9'h169;
   localparam logic [8:0] BAD_KEY  = 9'h0A5;
   // status field order: {key_ready, busy, unlocked, fail, lockout}
   localparam logic [4:0] ST_IDLE = 5'b00000;
   localparam logic [4:0] ST_LOAD = 5'b11000;
   localparam logic [4:0] ST_BUSY = 5'b01000;
   localparam logic [4:0] ST_UNL  = 5'b00100;
   localparam logic [4:0] ST_FAIL = 5'b00010;
   localparam logic [4:0] ST_LOCK = 5'b00001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       key_bit = 1'b0;
   logic       key_valid = 1'b0;
   logic [4:0] func_in = '0;
   logic       key_ready;
   logic [4:0] core_in;
   logic [1:0] core_out;
   logic [8:0] key_out;
   logic [1:0] func_out;
   logic       busy, unlocked, fail, lockout;
   logic [20:0] obs;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        st;
      logic        kv;
      logic        kb;
      logic [4:0]  fin;
      logic [20:0] exp;
   } vec_t;
   vec_t tbl[$];

   c17_key_unlock_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_bit(key_bit), .key_valid(key_valid),
      .key_ready(key_ready), .func_in(func_in), .core_in(core_in), .core_out(core_out),
      .key_out(key_out), .func_out(func_out), .busy(busy), .unlocked(unlocked),
      .fail(fail), .lockout(lockout)
   );

   always #5 clk = ~clk;

   // Reference c17 netlist; a wrong key corrupts the response to 11111.
   function automatic logic [1:0] c17(input logic [4:0] v);
      logic n10, n11, n16, n19;
      n10 = ~(v[4] & v[2]);
      n11 = ~(v[2] & v[1]);
      n16 = ~(v[3] & n11);
      n19 = ~(n11 & v[0]);
      return {~(n10 & n16), ~(n16 & n19)};
   endfunction

   assign core_out = c17(core_in) ^ (((key_out != GOOD_KEY) && (core_in == 5'b11111)) ? 2'b11 : 2'b00);
   assign obs = {key_ready, busy, unlocked, fail, lockout, key_out, core_in, func_out};

   function automatic logic [20:0] ex(input logic [4:0] st, input logic [8:0] k,
                                      input logic [4:0] ci, input logic [1:0] fo);
      return {st, k, ci, fo};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic kv, input logic kb, input logic [4:0] fin,
                      input logic [20:0] e);
      vec_t v;
      v.st = st; v.kv = kv; v.kb = kb; v.fin = fin; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic step(input logic st, input logic kv, input logic kb);
      start = st; key_valid = kv; key_bit = kb;
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [8:0] k, input logic par_good);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, k[i]);
`ifdef C17_KEY_PARITY_EN
      step(1'b0, 1'b1, par_good ? ~^k : ^k);
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; key_valid = 1'b0; key_bit = 1'b0; func_in = '0;
      #7;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] gk;
      gk = GOOD_KEY;

      add(0, 1, 1, 5'd0, ex(ST_IDLE, 9'h000, 5'b00000, 2'b00));
      add(0, 0, 0, 5'd0, ex(ST_IDLE, 9'h000, 5'b00000, 2'b00));
      add(0, 1, 0, 5'd0, ex(ST_IDLE, 9'h000, 5'b00000, 2'b00));
      add(1, 1, 1, 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 1, gk[0], 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 0, 1, 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 1, gk[1], 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 1, gk[2], 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(1, 0, 0, 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 1, gk[3], 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 1, gk[4], 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 1, gk[5], 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 1, gk[6], 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 1, gk[7], 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
`ifdef C17_KEY_PARITY_EN
      add(0, 1, gk[8], 5'd0, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      add(0, 1, 1'b0, 5'd0, ex(ST_BUSY, GOOD_KEY, 5'b00000, 2'b00));
`else
      add(0, 1, gk[8], 5'd0, ex(ST_BUSY, GOOD_KEY, 5'b00000, 2'b00));
`endif
      add(0, 0, 0, 5'd0, ex(ST_BUSY, GOOD_KEY, 5'b00000, 2'b00));
      add(0, 1, 1, 5'd0, ex(ST_BUSY, GOOD_KEY, 5'b11111, 2'b00));
      add(0, 0, 0, 5'd0, ex(ST_BUSY, GOOD_KEY, 5'b11111, 2'b00));
      add(0, 0, 0, 5'd0, ex(ST_BUSY, GOOD_KEY, 5'b10100, 2'b00));
      add(0, 0, 0, 5'd0, ex(ST_BUSY, GOOD_KEY, 5'b10100, 2'b00));
      add(0, 0, 0, 5'd0, ex(ST_BUSY, GOOD_KEY, 5'b01011, 2'b00));
      add(0, 0, 0, 5'd0, ex(ST_BUSY, GOOD_KEY, 5'b01011, 2'b00));
      add(0, 0, 0, 5'b11111, ex(ST_UNL, GOOD_KEY, 5'b11111, 2'b10));
      add(1, 1, 0, 5'b01011, ex(ST_UNL, GOOD_KEY, 5'b01011, 2'b11));
      add(0, 0, 0, 5'b10100, ex(ST_UNL, GOOD_KEY, 5'b10100, 2'b10));
      add(0, 0, 0, 5'b00000, ex(ST_UNL, GOOD_KEY, 5'b00000, 2'b00));

      #2;
      check("reset_during", obs, 21'd0);
      #21;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_idle", obs, 21'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         func_in = tbl[i].fin;
         step(tbl[i].st, tbl[i].kv, tbl[i].kb);
         check($sformatf("tbl%0d", i), obs, tbl[i].exp);
      end

      // asynchronous reset in the middle of a key load, then a clean unlock
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, gk[i]);
      check("midload_busy", obs, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
      #2 rst_n = 1'b0;
      #1 check("midload_async_reset", obs, 21'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_idle", obs, 21'd0);
      step(1'b1, 1'b0, 1'b0);
      load_key(GOOD_KEY, 1'b1);
      check("reload_apply0", obs, ex(ST_BUSY, GOOD_KEY, 5'b00000, 2'b00));
      repeat (7) step(1'b0, 1'b0, 1'b0);
      check("reload_not_yet", {31'd0, unlocked}, 32'd0);
      func_in = 5'b01011;
      step(1'b0, 1'b0, 1'b0);
      check("reload_unlocked", obs, ex(ST_UNL, GOOD_KEY, 5'b01011, 2'b11));

      // three wrong keys lead to lockout
      do_reset();
      for (int a = 1; a <= 3; a++) begin
         step(1'b1, 1'b0, 1'b0);
         check($sformatf("try%0d_load", a), obs, ex(ST_LOAD, 9'h000, 5'b00000, 2'b00));
         load_key(BAD_KEY, 1'b1);
         check($sformatf("try%0d_apply0", a), obs, ex(ST_BUSY, BAD_KEY, 5'b00000, 2'b00));
         repeat (3) step(1'b0, 1'b0, 1'b0);
         check($sformatf("try%0d_sample1", a), obs, ex(ST_BUSY, BAD_KEY, 5'b11111, 2'b00));
         step(1'b0, 1'b0, 1'b0);
         check($sformatf("try%0d_fail", a), obs, ex(ST_FAIL, 9'h000, 5'b00000, 2'b00));
         step(1'b0, 1'b0, 1'b0);
         if (a < 3)
            check($sformatf("try%0d_fail_hold", a), obs, ex(ST_FAIL, 9'h000, 5'b00000, 2'b00));
         else
            check("lockout_entry", obs, ex(ST_LOCK, 9'h000, 5'b00000, 2'b00));
      end
      func_in = 5'b11111;
      step(1'b1, 1'b0, 1'b0);
      check("lockout_no_ready", obs, ex(ST_LOCK, 9'h000, 5'b00000, 2'b00));
      load_key(GOOD_KEY, 1'b1);
      repeat (12) step(1'b0, 1'b0, 1'b0);
      check("lockout_terminal", obs, ex(ST_LOCK, 9'h000, 5'b00000, 2'b00));

`ifdef C17_KEY_PARITY_EN
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      load_key(GOOD_KEY, 1'b0);
      check("parity_bad_fail", obs, ex(ST_FAIL, 9'h000, 5'b00000, 2'b00));
      step(1'b1, 1'b0, 1'b0);
      load_key(GOOD_KEY, 1'b1);
      check("parity_good_apply", obs, ex(ST_BUSY, GOOD_KEY, 5'b00000, 2'b00));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
